adder_share_ctrl: RTL and testbench

ADDER_SHARE_CTRL -- requirements
Module: adder_share_ctrl

---
 rtl/adder_share_ctrl.sv | 121 ++++++++++++
 tb/tb_adder_share_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/adder_share_ctrl.sv
// adder_share_ctrl: lets two requesters share one external pipelined adder.
// Grants are combinational round-robin. Results return LAT+1 edges after acceptance, in acceptance order.
// A requester is held off only by arbitration loss, pause or reset. The response path takes no backpressure.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   pause                 blocks new grants; accepted ops still drain
//   req_valid/req_ready   per-requester request / one-hot grant (combinational)
//   a0,b0,cin0 / a1,b1,cin1  requester operands
//   add_a,add_b,add_cin   operands driven to the shared adder (zero when idle)
//   add_sum,add_cout      adder result, valid LAT edges after operand sample
//   rsp_valid,rsp_id,rsp_sum,rsp_cout  returned result, one strobe per op
//   in_flight             ops accepted but not yet returned
//   idle                  nothing in flight and nobody requesting
module adder_share_ctrl #(
  parameter int N   = 8,
  parameter int LAT = 2,
  localparam int IW = $clog2(LAT + 2)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pause,
  input  logic [1:0]    req_valid,
  output logic [1:0]    req_ready,
  input  logic [N-1:0]  a0,
  input  logic [N-1:0]  b0,
  input  logic          cin0,
  input  logic [N-1:0]  a1,
  input  logic [N-1:0]  b1,
  input  logic          cin1,
  output logic [N-1:0]  add_a,
  output logic [N-1:0]  add_b,
  output logic          add_cin,
  input  logic [N-1:0]  add_sum,
  input  logic          add_cout,
  output logic          rsp_valid,
  output logic          rsp_id,
  output logic [N-1:0]  rsp_sum,
  output logic          rsp_cout,
  output logic [IW-1:0] in_flight,
  output logic          idle
);

  logic           last_grant;
  logic           accept;
  logic           grant_id;
  // Tag stages track the adder's internal pipeline; rsp_* is the final stage.
  logic [LAT-1:0] tag_vld;
  logic [LAT-1:0] tag_id;

  always_comb begin
    req_ready = 2'b00;
    if (!reset && !pause) begin
      case (req_valid)
        2'b01:   req_ready = 2'b01;
        2'b10:   req_ready = 2'b10;
        // On a tie, the requester that did not win last time gets the grant.
        2'b11:   req_ready = last_grant ? 2'b01 : 2'b10;
        default: req_ready = 2'b00;
      endcase
    end
  end

  assign accept   = |req_ready;
  assign grant_id = req_ready[1];

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (req_ready[1]) begin
      add_a   = a1;
      add_b   = b1;
      add_cin = cin1;
    end else if (req_ready[0]) begin
      add_a   = a0;
      add_b   = b0;
      add_cin = cin0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_vld    <= '0;
      tag_id     <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_sum    <= '0;
      rsp_cout   <= 1'b0;
      last_grant <= 1'b1;
      in_flight  <= '0;
    end else begin
      tag_vld[0] <= accept;
      tag_id[0]  <= grant_id;
      for (int i = 1; i < LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_id[i]  <= tag_id[i-1];
      end

      // The adder result is only captured for real ops, so rsp_* holds otherwise.
      rsp_valid <= tag_vld[LAT-1];
      if (tag_vld[LAT-1]) begin
        rsp_id   <= tag_id[LAT-1];
        rsp_sum  <= add_sum;
        rsp_cout <= add_cout;
      end

      if (accept) last_grant <= grant_id;

      // The count drops on the edge where rsp_valid rises.
      case ({accept, tag_vld[LAT-1]})
        2'b10:   in_flight <= in_flight + IW'(1);
        2'b01:   in_flight <= in_flight - IW'(1);
        default: in_flight <= in_flight;
      endcase
    end
  end

  assign idle = (in_flight == '0) && (req_valid == 2'b00);

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Bench for adder_share_ctrl with N=8, LAT=2 and a two-stage behavioural adder.
// Applies one vector per clock cycle. Inputs are driven just after the rising edge and outputs are compared at the falling edge.
// Rows are hand-computed per cycle and include the reset, pause and arbitration corners.
module tb_adder_share_ctrl;

  logic       clk = 1'b0;
  logic       reset, pause;
  logic [1:0] req_valid, req_ready;
  logic [7:0] a0, b0, a1, b1;
  logic       cin0, cin1;
  logic [7:0] add_a, add_b, add_sum;
  logic       add_cin, add_cout;
  logic       rsp_valid, rsp_id, rsp_cout, idle;
  logic [7:0] rsp_sum;
  logic [1:0] in_flight;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  adder_share_ctrl #(.N(8), .LAT(2)) dut (
    .clk(clk), .reset(reset), .pause(pause),
    .req_valid(req_valid), .req_ready(req_ready),
    .a0(a0), .b0(b0), .cin0(cin0), .a1(a1), .b1(b1), .cin1(cin1),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .in_flight(in_flight), .idle(idle)
  );

  // Two-stage adder: operands sampled at edge t, result captured by the DUT at edge t+2.
  logic [8:0] s1 = '0, s2 = '0;
  always_ff @(posedge clk) begin
    s1 <= {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};
    s2 <= s1;
  end
  assign add_sum  = s2[7:0];
  assign add_cout = s2[8];

  typedef struct {
    logic       rst, pse;
    logic [1:0] rv;
    logic [7:0] a0, b0;
    logic       c0;
    logic [7:0] a1, b1;
    logic       c1;
    logic [1:0] rdy;
    logic [7:0] aa, ab;
    logic       ac;
    logic       v, id;
    logic [7:0] sum;
    logic       cout;
    logic [1:0] inf;
    logic       idl;
  } vec_t;

  task automatic chk(input string name, input int row, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0d expected %0d", name, row, act, exp);
    end
  endtask

  task automatic apply(input vec_t t, input int row);
    reset = t.rst; pause = t.pse; req_valid = t.rv;
    a0 = t.a0; b0 = t.b0; cin0 = t.c0;
    a1 = t.a1; b1 = t.b1; cin1 = t.c1;
    @(negedge clk);
    chk("req_ready", row, int'(req_ready), int'(t.rdy));
    chk("add_a",     row, int'(add_a),     int'(t.aa));
    chk("add_b",     row, int'(add_b),     int'(t.ab));
    chk("add_cin",   row, int'(add_cin),   int'(t.ac));
    chk("rsp_valid", row, int'(rsp_valid), int'(t.v));
    chk("rsp_id",    row, int'(rsp_id),    int'(t.id));
    chk("rsp_sum",   row, int'(rsp_sum),   int'(t.sum));
    chk("rsp_cout",  row, int'(rsp_cout),  int'(t.cout));
    chk("in_flight", row, int'(in_flight), int'(t.inf));
    chk("idle",      row, int'(idle),      int'(t.idl));
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[25];
  vec_t hs[9];

  initial begin
    //          rst pse rv     a0   b0  c0  a1   b1  c1  rdy    aa   ab  ac  v  id sum cout inf   idl
    tbl[0]  = '{1, 0, 2'b00,   0,   0, 0,   0,  0, 0, 2'b00,   0,   0, 0, 0, 0,  0, 0, 2'd0, 1};
    tbl[1]  = '{0, 0, 2'b01,  10,  20, 0,   0,  0, 0, 2'b01,  10,  20, 0, 0, 0,  0, 0, 2'd0, 0};
    tbl[2]  = '{0, 0, 2'b10,   0,   0, 0, 255,  1, 1, 2'b10, 255,   1, 1, 0, 0,  0, 0, 2'd1, 0};
    tbl[3]  = '{0, 0, 2'b01, 128, 128, 0,   0,  0, 0, 2'b01, 128, 128, 0, 0, 0,  0, 0, 2'd2, 0};
    tbl[4]  = '{0, 0, 2'b00,   0,   0, 0,   0,  0, 0, 2'b00,   0,   0, 0, 1, 0, 30, 0, 2'd2, 0};
    tbl[5]  = '{0, 0, 2'b00,   0,   0, 0,   0,  0, 0, 2'b00,   0,   0, 0, 1, 1,  1, 1, 2'd1, 0};
    tbl[6]  = '{0, 0, 2'b00,   0,   0, 0,   0,  0, 0, 2'b00,   0,   0, 0, 1, 0,  0, 1, 2'd0, 1};
    tbl[7]  = '{0, 0, 2'b00,   0,   0, 0,   0,  0, 0, 2'b00,   0,   0, 0, 0, 0,  0, 1, 2'd0, 1};
    tbl[8]  = '{1, 0, 2'b11,   1,   2, 0,   3,  4, 1, 2'b00,   0,   0, 0, 0, 0,  0, 1, 2'd0, 0};
    tbl[9]  = '{0, 0, 2'b11,   1,   2, 0,   3,  4, 1, 2'b01,   1,   2, 0, 0, 0,  0, 0, 2'd0, 0};
    tbl[10] = '{0, 0, 2'b11,   1,   2, 0,   3,  4, 1, 2'b10,   3,   4, 1, 0, 0,  0, 0, 2'd1, 0};
    tbl[11] = '{0, 0, 2'b11,   1,   2, 0,   3,  4, 1, 2'b01,   1,   2, 0, 0, 0,  0, 0, 2'd2, 0};
    tbl[12] = '{0, 0, 2'b11,   1,   2, 0,   3,  4, 1, 2'b10,   3,   4, 1, 1, 0,  3, 0, 2'd2, 0};
    tbl[13] = '{0, 1, 2'b11,   1,   2, 0,   3,  4, 1, 2'b00,   0,   0, 0, 1, 1,  8, 0, 2'd2, 0};
    tbl[14] = '{0, 1, 2'b11,   1,   2, 0,   3,  4, 1, 2'b00,   0,   0, 0, 1, 0,  3, 0, 2'd1, 0};
    tbl[15] = '{0, 1, 2'b11,   1,   2, 0,   3,  4, 1, 2'b00,   0,   0, 0, 1, 1,  8, 0, 2'd0, 0};
    tbl[16] = '{0, 1, 2'b00,   1,   2, 0,   3,  4, 1, 2'b00,   0,   0, 0, 0, 1,  8, 0, 2'd0, 1};
    tbl[17] = '{0, 0, 2'b10,   0,   0, 0,   5,  6, 0, 2'b10,   5,   6, 0, 0, 1,  8, 0, 2'd0, 0};
    tbl[18] = '{0, 0, 2'b10,   0,   0, 0,   5,  6, 0, 2'b10,   5,   6, 0, 0, 1,  8, 0, 2'd1, 0};
    tbl[19] = '{0, 0, 2'b10,   0,   0, 0,   5,  6, 0, 2'b10,   5,   6, 0, 0, 1,  8, 0, 2'd2, 0};
    tbl[20] = '{0, 0, 2'b11,   7,   8, 1,   5,  6, 0, 2'b01,   7,   8, 1, 1, 1, 11, 0, 2'd2, 0};
    tbl[21] = '{0, 0, 2'b00,   0,   0, 0,   0,  0, 0, 2'b00,   0,   0, 0, 1, 1, 11, 0, 2'd2, 0};
    tbl[22] = '{0, 0, 2'b00,   0,   0, 0,   0,  0, 0, 2'b00,   0,   0, 0, 1, 1, 11, 0, 2'd1, 0};
    tbl[23] = '{0, 0, 2'b00,   0,   0, 0,   0,  0, 0, 2'b00,   0,   0, 0, 1, 0, 16, 0, 2'd0, 1};
    tbl[24] = '{0, 0, 2'b00,   0,   0, 0,   0,  0, 0, 2'b00,   0,   0, 0, 0, 0, 16, 0, 2'd0, 1};

    // Reset lands one cycle after two acceptances; neither op may return.
    // The next tie goes to requester 0.
    hs[0] = '{0, 0, 2'b01,   1,   1, 0,   0,  0, 0, 2'b01,   1,   1, 0, 0, 0, 16, 0, 2'd0, 0};
    hs[1] = '{0, 0, 2'b01,   1,   1, 0,   0,  0, 0, 2'b01,   1,   1, 0, 0, 0, 16, 0, 2'd1, 0};
    hs[2] = '{1, 0, 2'b00,   0,   0, 0,   0,  0, 0, 2'b00,   0,   0, 0, 0, 0, 16, 0, 2'd2, 0};
    hs[3] = '{0, 0, 2'b00,   0,   0, 0,   0,  0, 0, 2'b00,   0,   0, 0, 0, 0,  0, 0, 2'd0, 1};
    hs[4] = '{0, 0, 2'b00,   0,   0, 0,   0,  0, 0, 2'b00,   0,   0, 0, 0, 0,  0, 0, 2'd0, 1};
    hs[5] = '{0, 0, 2'b11,   2,   3, 1,   9,  9, 0, 2'b01,   2,   3, 1, 0, 0,  0, 0, 2'd0, 0};
    hs[6] = '{0, 0, 2'b00,   0,   0, 0,   0,  0, 0, 2'b00,   0,   0, 0, 0, 0,  0, 0, 2'd1, 0};
    hs[7] = '{0, 0, 2'b00,   0,   0, 0,   0,  0, 0, 2'b00,   0,   0, 0, 0, 0,  0, 0, 2'd1, 0};
    hs[8] = '{0, 0, 2'b00,   0,   0, 0,   0,  0, 0, 2'b00,   0,   0, 0, 1, 0,  6, 0, 2'd0, 1};

    reset = 1'b1; pause = 1'b0; req_valid = 2'b00;
    a0 = '0; b0 = '0; cin0 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 25; i++) apply(tbl[i], i);
    for (int i = 0; i < 9; i++)  apply(hs[i], 100 + i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
